// File: rtl/board_move_arbiter.sv
// Board-level move arbiter. It runs a generation pass over the column units and drains
// their FIFOs round-robin into a single registered valid/ready move stream.
module board_move_arbiter #(
  parameter int NCOL    = 8,
  parameter int WORD_W  = 152,
  parameter int RD_LAT  = 1,
  parameter int CLR_CYC = 2,
  parameter int TIMEOUT = 4095
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      col_clr,
  input  logic [NCOL-1:0]           col_done,
  input  logic [NCOL-1:0]           col_empty,
  output logic [NCOL-1:0]           col_rden,
  input  logic [NCOL*WORD_W-1:0]    col_data,
  output logic [WORD_W-1:0]         out_data,
  output logic [$clog2(NCOL)-1:0]   out_col,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      pass_done,
  output logic                      timeout_err,
  output logic [15:0]               word_count
);
  localparam int PTR_W = $clog2(NCOL);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CLR  = 3'd1;
  localparam logic [2:0] S_SCAN = 3'd2;
  localparam logic [2:0] S_RDW  = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

  localparam logic [3:0]  CLR_LOAD = 4'(CLR_CYC - 1);
  localparam logic [1:0]  RDW_LOAD = 2'(RD_LAT);
  localparam logic [15:0] WD_LAST  = 16'(TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  logic [3:0]        clr_cnt_q, clr_cnt_d;
  logic [1:0]        rd_cnt_q, rd_cnt_d;
  logic [15:0]       wd_cnt_q, wd_cnt_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [NCOL-1:0]   rden_q, rden_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic [PTR_W-1:0]  out_col_q, out_col_d;
  logic              out_valid_q, out_valid_d;
  logic              timeout_err_q, timeout_err_d;
  logic [15:0]       word_count_q, word_count_d;

  logic              grant_vld;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  cand;
  logic [WORD_W-1:0] sel_word;
  logic              wd_expire;

  // Round-robin search starts just after the last granted column; NCOL is a power of two.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NCOL; k++) begin
      cand = rr_ptr_q + PTR_W'(k);
      if (!grant_vld && !col_empty[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NCOL; i++) begin
      if (rr_ptr_q == PTR_W'(i)) sel_word = col_data[i*WORD_W +: WORD_W];
    end
  end

  assign wd_expire = (TIMEOUT != 0) && (wd_cnt_q == WD_LAST);

  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    rd_cnt_d      = rd_cnt_q;
    wd_cnt_d      = wd_cnt_q;
    rr_ptr_d      = rr_ptr_q;
    rden_d        = '0;
    out_data_d    = out_data_q;
    out_col_d     = out_col_q;
    out_valid_d   = out_valid_q;
    timeout_err_d = timeout_err_q;
    word_count_d  = word_count_q;

    if (state_q inside {S_SCAN, S_RDW, S_OUT}) wd_cnt_d = wd_cnt_q + 16'd1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_CLR;
          clr_cnt_d     = CLR_LOAD;
          wd_cnt_d      = '0;
          word_count_d  = '0;
          timeout_err_d = 1'b0;
        end
      end
      S_CLR: begin
        if (clr_cnt_q == 4'd0) state_d = S_SCAN;
        else                   clr_cnt_d = clr_cnt_q - 4'd1;
      end
      S_SCAN: begin
        if (wd_expire) begin
          timeout_err_d = 1'b1;
          state_d       = S_FIN;
        end else if (grant_vld) begin
          rden_d[grant_idx] = 1'b1;
          rr_ptr_d          = grant_idx;
          out_col_d         = grant_idx;
          rd_cnt_d          = RDW_LOAD;
          state_d           = S_RDW;
        end else if ((&col_done) && (&col_empty)) begin
          state_d = S_FIN;
        end
      end
      S_RDW: begin
        if (wd_expire) begin
          timeout_err_d = 1'b1;
          state_d       = S_FIN;
        end else if (rd_cnt_q == 2'd0) begin
          out_data_d  = sel_word;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end else begin
          rd_cnt_d = rd_cnt_q - 2'd1;
        end
      end
      S_OUT: begin
        // A handshake on the expiring cycle still counts: the consumer already took the word.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          wd_cnt_d    = '0;
          if (word_count_q != 16'hFFFF) word_count_d = word_count_q + 16'd1;
          state_d     = S_SCAN;
        end else if (wd_expire) begin
          out_valid_d   = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      clr_cnt_q     <= '0;
      rd_cnt_q      <= '0;
      wd_cnt_q      <= '0;
      rr_ptr_q      <= PTR_W'(NCOL - 1);
      rden_q        <= '0;
      out_data_q    <= '0;
      out_col_q     <= '0;
      out_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      word_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      wd_cnt_q      <= wd_cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      rden_q        <= rden_d;
      out_data_q    <= out_data_d;
      out_col_q     <= out_col_d;
      out_valid_q   <= out_valid_d;
      timeout_err_q <= timeout_err_d;
      word_count_q  <= word_count_d;
    end
  end

  assign col_clr     = (state_q == S_CLR);
  assign busy        = (state_q != S_IDLE);
  assign pass_done   = (state_q == S_FIN);
  assign col_rden    = rden_q;
  assign out_data    = out_data_q;
  assign out_col     = out_col_q;
  assign out_valid   = out_valid_q;
  assign timeout_err = timeout_err_q;
  assign word_count  = word_count_q;

endmodule

// File: tb/tb_board_move_arbiter.sv
// Self-checking bench for board_move_arbiter: column FIFO models, a round-robin delivery
// model planned from the FIFO loads, and a per-cycle compare process.
module tb_board_move_arbiter;
  localparam int NCOL    = 8;
  localparam int WORD_W  = 152;
  localparam int RD_LAT  = 1;
  localparam int CLR_CYC = 2;
  localparam int TIMEOUT = 20;
  localparam int PTR_W   = $clog2(NCOL);

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic                   col_clr;
  logic [NCOL-1:0]        col_done;
  logic [NCOL-1:0]        col_empty;
  logic [NCOL-1:0]        col_rden;
  logic [NCOL*WORD_W-1:0] col_data;
  logic [WORD_W-1:0]      out_data;
  logic [PTR_W-1:0]       out_col;
  logic                   out_valid;
  logic                   out_ready;
  logic                   busy;
  logic                   pass_done;
  logic                   timeout_err;
  logic [15:0]            word_count;

  int checks_total  = 0;
  int checks_passed = 0;

  int                fifo_cnt [NCOL];
  int                col_seq  [NCOL];
  int                load_cnt [NCOL];
  logic [WORD_W-1:0] fifo_head[NCOL];

  int                exp_col[$];
  logic [WORD_W-1:0] exp_data[$];
  int                exp_words;
  bit                exp_timeout;
  int                model_ptr;
  int                got_cols[$];

  bit                prev_stall;
  logic [NCOL-1:0]   prev_rden;

  board_move_arbiter #(
    .NCOL(NCOL), .WORD_W(WORD_W), .RD_LAT(RD_LAT), .CLR_CYC(CLR_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .col_clr(col_clr), .col_done(col_done),
    .col_empty(col_empty), .col_rden(col_rden), .col_data(col_data), .out_data(out_data),
    .out_col(out_col), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .pass_done(pass_done), .timeout_err(timeout_err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  function automatic logic [WORD_W-1:0] wordOf(input int c, input int s);
    logic [31:0] mix;
    mix = 32'(c * 1000 + s) ^ 32'hA5A5_5A5A;
    return {8'(c), 16'(s), mix, 96'h0123_4567_89AB_CDEF_1357_9BDF};
  endfunction

  // Column units: cleared to a freshly generated load during col_clr, one-cycle read latency.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCOL; i++) begin
        fifo_cnt[i]  <= 0;
        col_seq[i]   <= 0;
        fifo_head[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCOL; i++) begin
        if (col_clr) begin
          fifo_cnt[i] <= load_cnt[i];
        end else if (col_rden[i] && fifo_cnt[i] > 0) begin
          fifo_head[i] <= wordOf(i, col_seq[i]);
          col_seq[i]   <= col_seq[i] + 1;
          fifo_cnt[i]  <= fifo_cnt[i] - 1;
        end
      end
    end
  end

  always_comb begin
    col_empty = '0;
    col_data  = '0;
    for (int i = 0; i < NCOL; i++) begin
      col_empty[i] = (fifo_cnt[i] == 0);
      col_data[i*WORD_W +: WORD_W] = fifo_head[i];
    end
  end

  task automatic checkOutput(input string name, input logic [WORD_W-1:0] got,
                             input logic [WORD_W-1:0] want);
    checks_total++;
    if (got === want) checks_passed++;
    else $display("[TB] FAIL %s: got %0h, want %0h", name, got, want);
  endtask

  task automatic failNow(input string name);
    checks_total++;
    $display("[TB] FAIL %s: expected event never happened within its cycle budget", name);
  endtask

  // Expected delivery order: repeatedly take the next non-empty column after the last one served.
  task automatic planOrder();
    int c[NCOL];
    int s[NCOL];
    int total;
    int pick;
    total = 0;
    for (int i = 0; i < NCOL; i++) begin
      c[i] = load_cnt[i];
      s[i] = col_seq[i];
      total += c[i];
    end
    exp_col.delete();
    exp_data.delete();
    exp_words   = total;
    exp_timeout = 0;
    for (int n = 0; n < total; n++) begin
      pick = -1;
      for (int k = 1; k <= NCOL; k++) begin
        if (pick < 0 && c[(model_ptr + k) % NCOL] > 0) pick = (model_ptr + k) % NCOL;
      end
      exp_col.push_back(pick);
      exp_data.push_back(wordOf(pick, s[pick]));
      c[pick]--;
      s[pick]++;
      model_ptr = pick;
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (!reset) begin
      prev_stall = 0;
      prev_rden  = '0;
    end else begin
      if (prev_rden != '0) checkOutput("rden_single_cycle", col_rden, '0);
      if (col_rden != '0) begin
        if (exp_col.size() == 0) failNow("rden_unplanned");
        else checkOutput("rden_onehot", col_rden, NCOL'(1) << exp_col[0]);
      end
      if (prev_stall && !timeout_err && exp_col.size() > 0) begin
        checkOutput("hold_valid", out_valid, 1);
        checkOutput("hold_col", out_col, exp_col[0]);
        checkOutput("hold_data", out_data, exp_data[0]);
        checkOutput("hold_no_rden", col_rden, '0);
      end
      if (out_valid && out_ready) begin
        if (exp_col.size() == 0) begin
          failNow("word_unplanned");
        end else begin
          checkOutput("word_col", out_col, exp_col[0]);
          checkOutput("word_data", out_data, exp_data[0]);
          void'(exp_col.pop_front());
          void'(exp_data.pop_front());
        end
        got_cols.push_back(int'(out_col));
      end
      if (pass_done) begin
        if (exp_timeout) begin
          checkOutput("fin_timeout_err", timeout_err, 1);
          checkOutput("fin_dropped_valid", out_valid, 0);
          exp_col.delete();
          exp_data.delete();
        end else begin
          checkOutput("fin_words_left", exp_col.size(), 0);
          checkOutput("fin_word_count", word_count, exp_words);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_rden  = col_rden;
    end
  end

  task automatic applyStimulus(input logic [NCOL-1:0] done, input logic rdy);
    @(negedge clk);
    col_done  = done;
    out_ready = rdy;
  endtask

  task automatic clearLoad();
    for (int i = 0; i < NCOL; i++) load_cnt[i] = 0;
  endtask

  task automatic pulseStart();
    got_cols.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic countClr(output int n);
    n = 0;
    while (col_clr && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic waitPassDone(input int budget);
    int k = 0;
    while (!pass_done && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!pass_done) failNow("pass_done_wait");
  endtask

  task automatic waitValid(input int budget);
    int k = 0;
    while (!out_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!out_valid) failNow("out_valid_wait");
  endtask

  task automatic waitWords(input int cnt, input int budget);
    int k = 0;
    while (got_cols.size() < cnt && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (got_cols.size() < cnt) failNow("words_wait");
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_col_clr"}, col_clr, 0);
    checkOutput({tag, "_col_rden"}, col_rden, 0);
    checkOutput({tag, "_out_data"}, out_data, 0);
    checkOutput({tag, "_out_col"}, out_col, 0);
    checkOutput({tag, "_out_valid"}, out_valid, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_pass_done"}, pass_done, 0);
    checkOutput({tag, "_timeout_err"}, timeout_err, 0);
    checkOutput({tag, "_word_count"}, word_count, 0);
  endtask

  task automatic checkIdleAfterPass(input string tag);
    @(negedge clk);
    checkOutput({tag, "_idle_busy"}, busy, 0);
    checkOutput({tag, "_pulse_len"}, pass_done, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    col_done  = '0;
    clearLoad();
    model_ptr   = NCOL - 1;
    exp_words   = 0;
    exp_timeout = 0;

    repeat (3) @(negedge clk);
    #1;
    checkResetOutputs("por");
    @(negedge clk);
    reset = 1'b1;

    // Empty pass: clear for two cycles, then straight to FIN.
    $display("[TB] empty pass");
    clearLoad();
    applyStimulus(8'hFF, 1'b1);
    planOrder();
    pulseStart();
    checkOutput("a_busy", busy, 1);
    countClr(n);
    checkOutput("a_clr_cycles", n, 2);
    waitPassDone(20);
    checkIdleAfterPass("a");

    // Round-robin over eight FIFOs of two words; done raised mid-pass.
    $display("[TB] round-robin");
    clearLoad();
    for (int i = 0; i < NCOL; i++) load_cnt[i] = 2;
    applyStimulus(8'h00, 1'b1);
    planOrder();
    pulseStart();
    waitWords(3, 100);
    applyStimulus(8'hFF, 1'b1);
    waitPassDone(200);
    checkOutput("rr_count", got_cols.size(), 16);
    for (int k = 0; k < 16; k++) begin
      if (k < got_cols.size()) checkOutput("rr_order", got_cols[k], k % 8);
    end
    checkOutput("rr_word_count", word_count, 16);
    checkIdleAfterPass("rr");

    // Single column 3 holding three words.
    $display("[TB] single column");
    clearLoad();
    load_cnt[3] = 3;
    applyStimulus(8'hFF, 1'b1);
    planOrder();
    pulseStart();
    waitPassDone(100);
    checkOutput("b_count", got_cols.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < got_cols.size()) checkOutput("b_col", got_cols[k], 3);
    end
    checkOutput("b_word_count", word_count, 3);
    checkIdleAfterPass("b");

    // Back-pressure on column 1: ten stalled cycles, then exactly one acceptance.
    $display("[TB] back-pressure");
    clearLoad();
    load_cnt[1] = 2;
    applyStimulus(8'hFF, 1'b0);
    planOrder();
    pulseStart();
    waitValid(30);
    for (int k = 0; k < 10; k++) begin
      checkOutput("bp_valid", out_valid, 1);
      checkOutput("bp_col", out_col, 1);
      checkOutput("bp_no_rden", col_rden, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("bp_one_accepted", word_count, 1);
    repeat (6) @(negedge clk);
    checkOutput("bp_second_waiting", out_valid, 1);
    checkOutput("bp_still_one", word_count, 1);
    out_ready = 1'b1;
    waitPassDone(40);
    checkOutput("bp_word_count", word_count, 2);
    checkIdleAfterPass("bp");

    // All columns report done while column 5 still holds four words.
    $display("[TB] done before drained");
    clearLoad();
    load_cnt[5] = 4;
    applyStimulus(8'hFF, 1'b1);
    planOrder();
    pulseStart();
    waitPassDone(100);
    checkOutput("e_count", got_cols.size(), 4);
    checkOutput("e_word_count", word_count, 4);
    checkIdleAfterPass("e");

    // Asynchronous reset while a word is waiting in OUT.
    $display("[TB] reset mid-pass");
    clearLoad();
    load_cnt[2] = 3;
    applyStimulus(8'hFF, 1'b0);
    planOrder();
    pulseStart();
    waitValid(30);
    #2 reset = 1'b0;
    #1;
    checkResetOutputs("arst");
    exp_col.delete();
    exp_data.delete();
    model_ptr = NCOL - 1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    clearLoad();
    load_cnt[2] = 1;
    applyStimulus(8'hFF, 1'b1);
    planOrder();
    pulseStart();
    checkOutput("f_busy", busy, 1);
    countClr(n);
    checkOutput("f_clr_cycles", n, 2);
    waitPassDone(40);
    checkOutput("f_count", got_cols.size(), 1);
    checkOutput("f_word_count", word_count, 1);
    checkIdleAfterPass("f");

    // Watchdog: column 7 never reports done and every FIFO is empty.
    $display("[TB] watchdog idle scan");
    clearLoad();
    applyStimulus(8'h7F, 1'b1);
    planOrder();
    exp_timeout = 1;
    pulseStart();
    countClr(n);
    n = 0;
    while (!timeout_err && n < 50) begin
      n++;
      @(negedge clk);
    end
    checkOutput("g_scan_cycles", n, 20);
    checkOutput("g_pass_done", pass_done, 1);
    @(negedge clk);
    checkOutput("g_idle_busy", busy, 0);
    checkOutput("g_err_sticky", timeout_err, 1);

    // Watchdog with a word stuck in OUT: the word is dropped, not counted.
    $display("[TB] watchdog pending word");
    clearLoad();
    load_cnt[0] = 1;
    applyStimulus(8'hFF, 1'b0);
    planOrder();
    exp_timeout = 1;
    pulseStart();
    checkOutput("h_err_cleared", timeout_err, 0);
    waitPassDone(60);
    checkOutput("h_timeout_err", timeout_err, 1);
    checkOutput("h_dropped", out_valid, 0);
    checkOutput("h_word_count", word_count, 0);
    checkIdleAfterPass("h");

    applyStimulus(8'hFF, 1'b1);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/board_move_arbiter.md
Name: board_move_arbiter

Overview:
Board-level scheduler for the eight column move-generation units.
- Sequences a generation pass: clears the columns, then waits for them to finish.
- Drains the eight column output FIFOs with round-robin arbitration into one registered valid/ready move stream.
- Reports when every column is done and every column FIFO is empty.
- Sits between the eight column units and the downstream move consumer (search/evaluation logic).

Parameters:
- NCOL, 8: number of column units; pointer width is clog2(NCOL)=3.
- WORD_W, 152: width of one column FIFO word (eight 19-bit move slots).
- RD_LAT, 1: cycles from col_rden to valid col_data; legal range 1..3.
- CLR_CYC, 2: cycles col_clr is held high at pass start; legal range 1..15.
- TIMEOUT, 4095: pass watchdog in cycles; 0 disables it.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 resets all state
- start  in  1  one-cycle pulse that begins a pass; sampled only in IDLE
- col_clr  out  1  synchronous reset to all column units during CLR
- col_done  in  NCOL  per-column done flags, bit i = column i
- col_empty  in  NCOL  per-column FIFO empty flags
- col_rden  out  NCOL  one-hot FIFO read enable, at most one bit high
- col_data  in  NCOL*WORD_W  column FIFO outputs; column i occupies bits [i*WORD_W +: WORD_W]
- out_data  out  WORD_W  registered move word
- out_col  out  3  source column of out_data
- out_valid  out  1  out_data/out_col valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- busy  out  1  high in every state except IDLE
- pass_done  out  1  one-cycle pulse at pass end
- timeout_err  out  1  sticky error, cleared by the next start
- word_count  out  16  words delivered this pass; saturates at 16'hFFFF

Behaviour:
- Reset values: col_clr=0, col_rden=0, out_data=0, out_col=0, out_valid=0, busy=0, pass_done=0, timeout_err=0, word_count=0, rr_ptr=7, state=IDLE.
- State encoding and codes are free; only the behaviour below is fixed.
- IDLE: start=1 goes to CLR. The same edge clears word_count and timeout_err, loads the CLR counter, and resets the watchdog.
- CLR: col_clr=1 for exactly CLR_CYC cycles, then go to SCAN.
- SCAN:
  - If any col_empty bit is 0, grant the first non-empty column searching from rr_ptr+1 mod 8 upward, wrapping.
  - On a grant: drive col_rden one-hot for exactly one cycle, set rr_ptr=grant and out_col=grant, go to RDW.
  - Else if col_done==8'hFF and col_empty==8'hFF, go to FIN.
  - Else stay in SCAN.
- RDW: wait RD_LAT cycles after the rden cycle, capture the granted column's slice of col_data into out_data, set out_valid=1, go to OUT.
- OUT:
  - Hold out_data, out_col and out_valid stable until out_valid&&out_ready.
  - On that handshake edge: out_valid=0, word_count+1 (saturating), go to SCAN.
- FIN: pass_done=1 for one cycle, then IDLE; busy drops in IDLE.
- Throughput: at most one word per RD_LAT+2 cycles. Only one FIFO read is ever outstanding.
- Watchdog:
  - Counts every cycle in SCAN, RDW and OUT; reloads to 0 on every accepted word.
  - Reaching TIMEOUT sets timeout_err=1 and forces FIN.
  - If the timeout lands while out_valid=1, the pending word is dropped: out_valid=0, not counted.
- Boundaries:
  - start outside IDLE is ignored; no restart.
  - A col_done bit that rises while its FIFO is still non-empty has no effect; the column is drained normally.
  - A column whose empty flag rises during RDW is still captured; the read was issued against a non-empty flag.
  - col_done/col_empty are not examined during CLR.
  - Asynchronous reset mid-pass returns immediately to IDLE with all outputs at reset values. Any in-flight FIFO word is lost; the next pass begins with col_clr.
  - out_ready high while out_valid=0 has no effect.

Test Plan:
- Reset/clear: assert reset=0 mid-OUT with out_valid=1 -> all outputs 0 asynchronously. Release, pulse start -> col_clr high exactly 2 cycles, busy=1.
- Single column: only col_empty[3]=0 for 3 words, then all done/empty -> out_col=3 three times, col_rden=8'h08 three single-cycle pulses, word_count=3, pass_done pulse, busy=0.
- Round-robin: all eight FIFOs hold 2 words, out_ready=1 -> out_col order 0,1,...,7,0,1,...,7; word_count=16.
- Back-pressure: out_ready=0 for 10 cycles -> out_data and out_col constant, out_valid=1, no further col_rden. Raise out_ready -> exactly one word accepted.
- Done before drained: col_done=8'hFF while column 5 still holds 4 words -> all 4 delivered before pass_done. pass_done never precedes the last word.
- Watchdog: TIMEOUT=20, col_done stuck at 8'h7F, all empty -> timeout_err=1 at cycle 20 of SCAN, pass_done pulse. Next start clears timeout_err.
